// File: rtl/ram3_pkg.sv
// rtl/ram3_pkg.sv - shared sizes, types and access-state encoding for ram3
package ram3_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Kind of access taken at the most recent clock edge; selects the output source.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2
  } act_e;

endpackage

// File: rtl/ram3_if.sv
// rtl/ram3_if.sv - host-side access bus of the ram3 scratch memory
interface ram3_if;
  import ram3_pkg::*;

  data_t data_in;
  addr_t addr;
  logic  wr;
  logic  cs;
  data_t data_out;
  logic  rd_valid;

  modport master (
    output data_in, addr, wr, cs,
    input  data_out, rd_valid
  );

  modport slave (
    input  data_in, addr, wr, cs,
    output data_out, rd_valid
  );

endinterface

// File: rtl/ram3_array.sv
// rtl/ram3_array.sv - bare 1024x8 storage, synchronous write and registered read
module ram3_array
  import ram3_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rdata
);

  data_t mem [DEPTH];

  // No reset on the array or its read register so the block maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram3.sv
// rtl/ram3.sv - single-port 1024x8 RAM with chip select, write-first output and read strobe
module ram3
  import ram3_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  ram3_if.slave  bus
);

  act_e  act_q, act_d;
  data_t out_q, out_d;
  data_t rdata;
  logic  we;

  // Writes are gated by reset so a held-low rst_n never disturbs the stored contents.
  assign we = bus.cs & bus.wr & rst_n;

  ram3_array u_array (
    .clk   (clk),
    .we    (we),
    .addr  (bus.addr),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

  // Next access state and hold value: a pending read result is folded into the
  // hold register so it survives idle cycles; a write replaces it with the write data.
  always_comb begin
    act_d = ACT_IDLE;
    out_d = (act_q == ACT_READ) ? rdata : out_q;
    if (bus.cs) begin
      if (bus.wr) begin
        act_d = ACT_WRITE;
        out_d = bus.data_in;
      end else begin
        act_d = ACT_READ;
      end
    end
  end

  // Output-side registers; the only state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= ACT_IDLE;
      out_q <= '0;
    end else begin
      act_q <= act_d;
      out_q <= out_d;
    end
  end

  // Fresh read data comes straight from the array's read register; otherwise the
  // hold register. Both sources are flops, and reset forces the hold path at once.
  assign bus.data_out = (act_q == ACT_READ) ? rdata : out_q;
  assign bus.rd_valid = (act_q == ACT_READ);

endmodule

// File: tb/tb_ram3.sv
// tb/tb_ram3.sv - scoreboard bench for ram3
module tb_ram3;
  import ram3_pkg::*;

  logic clk;
  logic rst_n;
  ram3_if bus ();

  ram3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp;
  int    n_err;
  data_t exp_q [$];
  data_t model [DEPTH];
  logic  mon_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input addr_t a, input data_t d);
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    model[a]    = d;
  endtask

  task automatic do_read(input addr_t a, input data_t exp);
    @(negedge clk);
    bus.cs   = 1'b1;
    bus.wr   = 1'b0;
    bus.addr = a;
    exp_q.push_back(exp);
  endtask

  task automatic do_idle();
    @(negedge clk);
    bus.cs = 1'b0;
    bus.wr = 1'b0;
  endtask

  // Monitor: every valid read result is popped from the scoreboard and compared.
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        check("rd_data", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    bus.cs = 1'b0;
    bus.wr = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", {24'd0, bus.data_out}, 32'd0);
    check("reset_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill mem[i] = 3*i mod 256.
    for (int i = 0; i < DEPTH; i++) begin
      do_write(addr_t'(i), data_t'((3 * i) % 256));
    end

    do_read(10'd5,    8'd15);
    do_read(10'd86,   8'd2);
    do_read(10'd100,  8'd44);
    do_read(10'd1023, 8'd253);
    do_read(10'd0,    8'd0);
    do_read(10'd100,  8'd44);

    // Chip select low: write attempt must be ignored and output held.
    @(negedge clk);
    bus.cs      = 1'b0;
    bus.wr      = 1'b1;
    bus.addr    = 10'd5;
    bus.data_in = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("cs0_hold_data", {24'd0, bus.data_out}, 32'd44);
      check("cs0_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    end
    do_read(10'd5, 8'd15);

    // Random reads against the fill pattern.
    for (int k = 0; k < 20; k++) begin
      automatic addr_t ra = addr_t'($urandom_range(1023, 0));
      do_read(ra, data_t'((3 * int'(ra)) % 256));
    end

    // Write-first then read-after-write.
    do_write(10'd300, 8'h5A);
    @(posedge clk);
    #1;
    check("wfirst_data_out", {24'd0, bus.data_out}, 32'h5A);
    check("wfirst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    do_read(10'd300, model[300]);
    do_idle();

    // Asynchronous reset while data_out shows 0xFD.
    do_read(10'd1023, 8'd253);
    @(posedge clk);
    #3;
    check("pre_reset_data_out", {24'd0, bus.data_out}, 32'hFD);
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("async_rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 10'd1023;
    bus.data_in = 8'h00;
    @(posedge clk);
    #1;
    check("in_rst_data_out", {24'd0, bus.data_out}, 32'd0);
    @(negedge clk);
    bus.cs = 1'b0;
    bus.wr = 1'b0;
    rst_n  = 1'b1;
    do_read(10'd1023, 8'd253);
    do_idle();

    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram3.md
Name: ram3

Overview:
- Single-port synchronous 1024 x 8 static RAM with chip select and write enable.
- Stores bytes written by a host/controller and returns them on a registered read port.
- Used as a generic scratch/data memory.
- One clock domain; asynchronous active-low reset clears only the output register, never the array.

Parameters:
- ADDR_W, 10, address width; depth = 2**ADDR_W words (1024).
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  rising-edge clock for all sequential logic.
- rst_n  input  1  asynchronous active-low reset.
- data_out  output  DATA_W  registered read data.
- data_in  input  DATA_W  write data.
- addr  input  ADDR_W  word address, 0..1023.
- wr  input  1  write enable, 1 = write, 0 = read; qualified by cs.
- cs  input  1  chip select, active high; when low the RAM ignores all inputs.
- rd_valid  output  1  high for exactly the cycle data_out carries a fresh read result.

Behaviour:
- Reset:
  - Assertion of rst_n=0 immediately forces data_out=0 and rd_valid=0, independent of clk.
  - Array contents are not cleared and remain unchanged across reset.
  - While rst_n=0, writes are blocked.
- Write: at a rising clk edge with rst_n=1, cs=1 and wr=1, mem[addr] <= data_in.
  - Takes effect at that edge and is visible to a read issued on the next edge.
- Write cycle outputs:
  - data_out is write-first: data_out <= data_in, so the written value appears one cycle later.
  - rd_valid <= 0.
- Read: at a rising edge with cs=1 and wr=0, data_out <= mem[addr] and rd_valid <= 1.
  - Latency is exactly one clock: address sampled at edge N, data valid after edge N.
- Idle: at an edge with cs=0, data_out holds its previous value, rd_valid <= 0, and memory is unchanged.
  - wr is don't-care when cs=0.
- Address range:
  - Every address 0..1023 is valid; there is no out-of-range case, and the full ADDR_W bits are used.
  - Address 1023 and address 0 are independent locations; there is no wrap logic.
- Back-to-back accesses:
  - Any mix of reads and writes is allowed every cycle; no handshake and no stall.
  - A read of an address on the cycle after it was written returns the new data.
- Uninitialised locations read as X in simulation; the bench must write before reading.
- Reset de-assertion is taken synchronously in the output register; the first access is honoured on the first edge with rst_n=1.
- No parity, no byte enables, no multi-port access.

Decomposition:
- Package ram3_pkg:
  - localparams ADDR_W=10, DATA_W=8, DEPTH=1024.
  - typedefs addr_t and data_t.
- One sub-module is natural: ram3_array, the bare storage.
  - Synchronous write with we, addr, wdata.
  - Synchronous read with rdata.
  - Infers block RAM.
- The top module ram3 holds the cs/wr decode, the write-first mux, the data_out/rd_valid registers and the reset.

Test Plan:
- Fill and read back:
  - Write mem[i] = (3*i) mod 256 for i = 0..1023 (cs=1, wr=1, one per cycle).
  - Then read: addr 5 -> 15; addr 86 -> 2; addr 100 -> 44; addr 1023 -> 253; addr 0 -> 0.
  - Each result appears one cycle after the address is sampled, with rd_valid=1.
- Chip select gating:
  - After the fill, drive cs=0, wr=1, addr=5, data_in=0xAA for several cycles.
  - Required: data_out unchanged, rd_valid=0, and a later read of addr 5 still returns 15.
- Write-first and back-to-back:
  - Write 0x5A to addr 300, then read addr 300 on the next cycle.
  - Required: data_out=0x5A during the write's output cycle and again after the read, with rd_valid=1 only after the read.
- Random reads: 20 random addresses in 0..1023 after the fill -> each data_out = (3*addr) mod 256.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously between clock edges while data_out=0xFD.
  - Required: data_out=0 and rd_valid=0 immediately.
  - After release, a read of addr 1023 returns 253, proving the contents survived reset.
